mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mul_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//   Two-requester front end for a single sequential shift-add multiplier.
//   A requester raises its req bit with operands on its a/b inputs and holds
//   the request until it sees a one-cycle ack pulse.  Operands are latched at
//   grant, so later operand changes do not disturb the product in flight.
//   Simultaneous requests alternate using a last-served pointer.  A zero
//   operand skips the multiplier and completes in one cycle with result 0.
//
//   Ports
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     req[1:0]  request levels, bit i held until ack[i]
//     a0, b0    requester 0 operands (BITS each)
//     a1, b1    requester 1 operands (BITS each)
//     ack[1:0]  one-cycle completion pulse to the granted requester
//     result    registered 2*BITS product of the last completed operation
//     grant_id  requester currently or most recently served
//     busy      high whenever the controller is not idle
//
//   Timing (nonzero operands, idle multiplier): req seen in IDLE cycle 0,
//   START cycle 1, WAIT cycles 2..BITS+2, ack in cycle BITS+3.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mul_arbiter_mult
//   Unsigned sequential multiplier, one partial product per clock.
//   en (one cycle) loads the operands; done drops the following cycle and
//   rises again BITS cycles later with result = data_a * data_b.
//
//   Ports
//     clk      clock
//     en       start pulse, samples data_a/data_b
//     data_a   multiplicand (BITS)
//     data_b   multiplier (BITS)
//     result   product (2*BITS), valid while done is high after a run
//     done     high when no operation is in progress
// -----------------------------------------------------------------------------
module mul_arbiter_mult #(
  parameter int BITS = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BITS-1:0]   data_a,
  input  logic [BITS-1:0]   data_b,
  output logic [2*BITS-1:0] result,
  output logic              done
);

  localparam int CW = $clog2(BITS + 1);

  logic [CW-1:0]     cnt;
  logic [2*BITS-1:0] acc;
  logic [2*BITS-1:0] mcand;
  logic [BITS-1:0]   mplier;

  // NOTE: this datapath deliberately has no reset.  An arbiter reset must not
  // abort a run in progress: the multiplier drains on its own and the
  // controller waits for done.  From an arbitrary power-up value the down
  // counter reaches zero (done) within 2**CW-1 cycles, so no reset is needed
  // for it to become usable.
  always_ff @(posedge clk) begin
    if (en) begin
      acc    <= '0;
      mcand  <= {{BITS{1'b0}}, data_a};
      mplier <= data_b;
      cnt    <= CW'(BITS);
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  assign result = acc;
  assign done   = (cnt == '0);

endmodule

module mul_arbiter #(
  parameter int BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [BITS-1:0]   a0,
  input  logic [BITS-1:0]   b0,
  input  logic [BITS-1:0]   a1,
  input  logic [BITS-1:0]   b1,
  output logic [1:0]        ack,
  output logic [2*BITS-1:0] result,
  output logic              grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    ACK
  } state_t;

  state_t            state;
  logic              last;      // last-served requester
  logic [BITS-1:0]   op_a;
  logic [BITS-1:0]   op_b;

  logic              mul_en;
  logic [2*BITS-1:0] mul_result;
  logic              mul_done;

  logic              win;
  logic [BITS-1:0]   sel_a;
  logic [BITS-1:0]   sel_b;

  // Arbitration: a lone request wins outright; on a tie the requester that
  // was not served last wins.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    win   = 1'b0;
    sel_a = a0;
    sel_b = b0;
    if (req == 2'b11) begin
      win = ~last;
    end else begin
      win = req[1];
    end
    if (win) begin
      sel_a = a1;
      sel_b = b1;
    end
  end

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ack      <= 2'b00;
      result   <= '0;
      grant_id <= 1'b0;
      busy     <= 1'b0;
      mul_en   <= 1'b0;
      last     <= 1'b1;   // requester 0 wins the first tie
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      ack    <= 2'b00;
      mul_en <= 1'b0;
      case (state)
        IDLE: begin
          // Grant only once the multiplier is free; after a mid-operation
          // reset it may still be draining the aborted run.
          if ((req != 2'b00) && mul_done) begin
            grant_id <= win;
            last     <= win;
            op_a     <= sel_a;
            op_b     <= sel_b;
            busy     <= 1'b1;
            if ((sel_a == '0) || (sel_b == '0)) begin
              // Zero operand: product is known, skip the multiplier.
              result <= '0;
              ack    <= {win, ~win};
              state  <= ACK;
            end else begin
              mul_en <= 1'b1;
              state  <= START;
            end
          end
        end
        START: begin
          // mul_en was high for this cycle only; the multiplier has now
          // captured op_a/op_b.
          state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            result <= mul_result;
            ack    <= {grant_id, ~grant_id};
            state  <= ACK;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  mul_arbiter_mult #(
    .BITS (BITS)
  ) u_mult (
    .clk    (clk),
    .en     (mul_en),
    .data_a (op_a),
    .data_b (op_b),
    .result (mul_result),
    .done   (mul_done)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
//   Directed bench for mul_arbiter (BITS=16): reset state, basic latency and
//   product, tie alternation, zero shortcut, operand isolation after grant,
//   request drop before ack, mid-operation reset, then a randomised
//   back-to-back run checked against products computed here.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge;
//   "cycle n" means the interval after the n-th edge counted from the cycle in
//   which the request is first presented (cycle 0).
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

  localparam int BITS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [BITS-1:0]   a0, b0, a1, b1;
  logic [1:0]        ack;
  logic [2*BITS-1:0] result;
  logic              grant_id;
  logic              busy;

  int tests    = 0;
  int fails    = 0;
  int en_count = 0;

  mul_arbiter #(
    .BITS (BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a0       (a0),
    .b0       (b0),
    .a1       (a1),
    .b1       (b1),
    .ack      (ack),
    .result   (result),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Count multiplier start pulses to show the zero shortcut never uses it.
  always @(posedge clk) begin
    if (dut.mul_en) en_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until an ack appears or the budget expires; lat is edges taken.
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while ((ack == 2'b00) && (lat < 200));
  endtask

  // Random operands with a generous share of zeros to exercise the shortcut.
  function automatic logic [BITS-1:0] rand_op();
    if ($urandom_range(0, 3) == 0) return '0;
    return BITS'($urandom);
  endfunction

  logic [2*BITS-1:0] exp_p [2];
  int                wait_n [2];

  task automatic raise(input int i);
    if (i == 0) begin
      a0 = rand_op();
      b0 = rand_op();
      exp_p[0] = (2*BITS)'(a0) * (2*BITS)'(b0);
    end else begin
      a1 = rand_op();
      b1 = rand_op();
      exp_p[1] = (2*BITS)'(a1) * (2*BITS)'(b1);
    end
    req[i] = 1'b1;
  endtask

  initial begin
    int lat;
    int en0;
    int ops;
    int cyc;
    logic idle_ok;

    rst = 1'b1;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // ---- Reset state ----
    repeat (3) step();
    check("rst_ack", ack, 2'b00);
    check("rst_result", result, 0);
    check("rst_grant", grant_id, 1'b0);
    check("rst_busy", busy, 1'b0);

    // ---- Single request, 3*7, ack in cycle 19 ----
    rst = 1'b0;
    req = 2'b01; a0 = 16'd3; b0 = 16'd7;
    step();                                   // cycle 1
    check("basic_busy_c1", busy, 1'b1);
    check("basic_grant_c1", grant_id, 1'b0);
    repeat (17) step();                       // cycle 18
    check("basic_no_ack_c18", ack, 2'b00);
    step();                                   // cycle 19
    check("basic_ack_c19", ack, 2'b01);
    check("basic_result", result, 21);
    check("basic_grant", grant_id, 1'b0);
    req = 2'b00;
    step();                                   // cycle 20
    check("basic_ack_off", ack, 2'b00);
    check("basic_busy_off", busy, 1'b0);

    // ---- Ties from reset, both requests held ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 2'b11;
    a0 = 16'hFFFF; b0 = 16'hFFFF; a1 = 16'd2; b1 = 16'd5;
    wait_ack(lat);
    check("tie1_lat", lat, 19);
    check("tie1_ack", ack, 2'b01);
    check("tie1_result", result, 32'hFFFE0001);
    check("tie1_grant", grant_id, 1'b0);
    wait_ack(lat);
    check("tie2_lat", lat, 20);
    check("tie2_ack", ack, 2'b10);
    check("tie2_result", result, 10);
    check("tie2_grant", grant_id, 1'b1);
    wait_ack(lat);
    check("tie3_lat", lat, 20);
    check("tie3_ack", ack, 2'b01);
    check("tie3_result", result, 32'hFFFE0001);
    req = 2'b00;
    step();

    // ---- Zero shortcut on requester 1 ----
    en0 = en_count;
    req = 2'b10; a1 = 16'd0; b1 = 16'd1234;
    wait_ack(lat);
    check("zero_lat", lat, 1);
    check("zero_ack", ack, 2'b10);
    check("zero_result", result, 0);
    check("zero_grant", grant_id, 1'b1);
    req = 2'b00;
    step();
    check("zero_busy_off", busy, 1'b0);
    check("zero_no_en", en_count, en0);

    // ---- Operands change after grant, request dropped before ack ----
    req = 2'b01; a0 = 16'd100; b0 = 16'd200;
    step();                                   // cycle 1
    a0 = 16'd1; b0 = 16'd1;
    check("iso_grant", grant_id, 1'b0);
    repeat (4) step();                        // cycle 5
    req = 2'b00;
    check("iso_result_held", result, 0);
    wait_ack(lat);
    check("iso_lat", lat, 14);
    check("iso_ack", ack, 2'b01);
    check("iso_result", result, 20000);
    step();
    check("iso_busy_off", busy, 1'b0);

    // ---- Reset during WAIT, request held ----
    req = 2'b01; a0 = 16'd3; b0 = 16'd7;
    repeat (5) step();                        // cycle 5, in WAIT
    check("mid_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_busy_rst", busy, 1'b0);
    check("mid_ack_rst", ack, 2'b00);
    check("mid_result_rst", result, 0);
    check("mid_grant_rst", grant_id, 1'b0);
    step();                                   // cycle 6
    rst = 1'b0;
    a0 = 16'd5; b0 = 16'd6;
    idle_ok = 1'b1;
    for (int c = 7; c <= 18; c++) begin
      step();
      if (busy !== 1'b0 || ack !== 2'b00) idle_ok = 1'b0;
    end
    check("mid_wait_done", idle_ok, 1'b1);
    step();                                   // cycle 19
    check("mid_busy_regrant", busy, 1'b1);
    wait_ack(lat);
    check("mid_lat", lat, 18);
    check("mid_ack", ack, 2'b01);
    check("mid_result", result, 30);
    req = 2'b00;
    step();

    // ---- Random back-to-back traffic ----
    ops = 0;
    cyc = 0;
    wait_n[0] = 0;
    wait_n[1] = 0;
    while ((ops < 1000) && (cyc < 60000)) begin
      step();
      cyc++;
      check("rand_onehot", (ack == 2'b11), 1'b0);
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          check("rand_result", result, exp_p[i]);
          check("rand_grant", grant_id, i[0]);
          if (req[1-i]) begin
            wait_n[1-i]++;
            check("rand_starve", (wait_n[1-i] <= 1), 1'b1);
          end
          wait_n[i] = 0;
          ops++;
          if ($urandom_range(0, 1) == 1) raise(i);
          else req[i] = 1'b0;
        end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          raise(i);
        end
      end
    end
    check("rand_ops_done", ops, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
